// File: rtl/lamp_dwell_timer.sv
// Purpose : times how long each lamp colour is shown and strobes the lamp stage to advance.
// Latency : step rises N+1 cycles after LOAD for a dwell of N (0 counts as 1); lamp change expected within ACK_MAX cycles.
// Backpressure: enable low pauses the dwell count; a lamp stage that never changes code raises a sticky fault.
// Ports   : clock, reset_n (async, active-low); enable, light[0:2] (100 R, 010 G, 001 Y),
//           red/green/yellow_dwell, clear -> step (1-cycle strobe), fault (sticky), remaining (dwell counter).
module lamp_dwell_timer #(
  parameter int CNT_W   = 8,
  parameter int ACK_MAX = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [0:2]       light,
  input  logic [CNT_W-1:0] red_dwell,
  input  logic [CNT_W-1:0] green_dwell,
  input  logic [CNT_W-1:0] yellow_dwell,
  input  logic             clear,
  output logic             step,
  output logic             fault,
  output logic [CNT_W-1:0] remaining
);

  localparam int ACK_W = (ACK_MAX < 2) ? 1 : $clog2(ACK_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    STEP  = 3'd3,
    WAIT  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  logic [ACK_W-1:0]   ack_inc;
  logic [0:2]         cur_q, cur_d;
  logic               step_q, fault_q;
  logic               light_ok;
  logic [CNT_W-1:0]   dwell_sel;
  logic [CNT_W-1:0]   dwell_eff;

  // Decode the incoming lamp code; anything that is not exactly one-hot is invalid.
  always_comb begin
    light_ok  = 1'b1;
    dwell_sel = '0;
    case (light)
      3'b100:  dwell_sel = red_dwell;
      3'b010:  dwell_sel = green_dwell;
      3'b001:  dwell_sel = yellow_dwell;
      default: light_ok  = 1'b0;
    endcase
  end

  // A programmed dwell of zero still shows the colour for one enabled cycle.
  assign dwell_eff = (dwell_sel == '0) ? CNT_W'(1) : dwell_sel;
  assign ack_inc   = ack_q + ACK_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (light_ok) begin
          cur_d   = light;
          cnt_d   = dwell_eff;
          state_d = COUNT;
        end else begin
          cnt_d   = '0;
          state_d = FAULT;
        end
      end
      COUNT: begin
        // Lamp code is deliberately not watched here; only WAIT checks it.
        if (enable) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = STEP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      STEP: begin
        cnt_d   = '0;
        ack_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (light != cur_q) begin
          state_d = LOAD;
        end else begin
          ack_d = ack_inc;
          if (ack_inc == ACK_W'(ACK_MAX)) state_d = FAULT;
        end
      end
      FAULT: begin
        // Clear is only looked at once already sitting in FAULT, so a clear
        // coincident with the fault-causing cycle is not honoured.
        cnt_d = '0;
        if (clear) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      cur_q   <= 3'b000;
      step_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      cur_q   <= cur_d;
      // Outputs registered from the next state so they line up with the state they describe.
      step_q  <= (state_d == STEP);
      fault_q <= (state_d == FAULT);
    end
  end

  assign step      = step_q;
  assign fault     = fault_q;
  assign remaining = cnt_q;

endmodule

// File: doc/lamp_dwell_timer.md
LAMP_DWELL_TIMER -- requirements
Module: lamp_dwell_timer

Interface
REQ-001 Parameter CNT_W, default 8: width of dwell inputs and the internal dwell counter.
REQ-002 Parameter ACK_MAX, default 15: maximum cycles to wait for the lamp code to change after a step.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port enable, input, 1: run/hold; leaves IDLE and gates counting.
REQ-006 Port light, input, [0:2]: current lamp code from the cyclic lamp stage (100 RED, 010 GREEN, 001 YELLOW).
REQ-007 Port red_dwell, green_dwell, yellow_dwell, input, CNT_W each: dwell per colour, in enabled cycles.
REQ-008 Port clear, input, 1: fault acknowledge.
REQ-009 Port step, output, 1: one-cycle advance strobe to the lamp stage.
REQ-010 Port fault, output, 1: sticky error flag.
REQ-011 Port remaining, output, CNT_W: current dwell counter value.

Function
REQ-012 States: IDLE, LOAD, COUNT, STEP, WAIT, FAULT; all outputs are registered.
REQ-013 IDLE: enable=1 -> LOAD; otherwise stay in IDLE.
REQ-014 LOAD, valid one-hot light: capture light as cur_light; load the counter with that colour's dwell; go to COUNT.
REQ-015 LOAD, dwell of 0: treated as 1.
REQ-016 LOAD, invalid light (000 or multi-hot): go to FAULT.
REQ-017 LOAD ignores enable.
REQ-018 COUNT, enable=1: if counter==1, go to STEP; else decrement the counter.
REQ-019 COUNT, enable=0: hold state and counter unchanged (pause).
REQ-020 COUNT: a light change before STEP causes no transition; the check happens only in WAIT.
REQ-021 Dwell N, enable held high: LOAD at cycle t, step high at cycle t+N+1, exactly one cycle wide.
REQ-022 STEP: step=1; counter cleared to 0; go to WAIT with the ack counter set to 0.
REQ-023 WAIT, light != cur_light: go to LOAD (re-evaluate the new code).
REQ-024 WAIT, light == cur_light: increment the ack counter; on reaching ACK_MAX, go to FAULT.
REQ-025 FAULT: fault=1, step=0, counter=0; stay until clear=1, then go to IDLE with fault=0 on the next cycle.
REQ-026 clear outside FAULT is ignored.
REQ-027 A fault condition and clear in the same cycle: fault is taken; clear is not honoured until a later cycle in FAULT.
REQ-028 Dwell inputs are sampled only in LOAD; changes during COUNT take effect at the next LOAD.
REQ-029 remaining equals the counter register, and reads 0 outside COUNT.
REQ-030 step is never high in two consecutive cycles.

Reset
REQ-031 reset_n low (asynchronous, any state): state=IDLE, step=0, fault=0, remaining=0, ack counter=0, cur_light=000.
REQ-032 Release of reset_n takes effect on the following rising edge of clock.
REQ-033 Reset mid-COUNT discards the count.
REQ-034 After reset, the first step requires a full dwell.

Verification
REQ-035 Basic dwell: enable=1, light=100, red_dwell=3 -> step at 4th cycle after LOAD; remaining shows 3,2,1 in COUNT.
REQ-036 Pause: green_dwell=5, enable dropped for 4 cycles mid-COUNT -> step delayed by exactly 4 cycles.
REQ-037 Full cycle with a lamp model: dwells R=2, G=4, Y=1 -> step spacing matches each colour's dwell plus LOAD/STEP/WAIT overhead, sequence G,Y,R repeats.
REQ-038 Stuck lamp: light held at 010 after step for ACK_MAX=15 cycles -> fault=1, step=0.
REQ-039 Fault recovery: then clear=1 -> IDLE next cycle, fault=0.
REQ-040 Invalid code: light=110 at LOAD -> FAULT, fault=1.
REQ-041 Invalid code with clear: clear=1 in that same cycle -> remains in FAULT.
REQ-042 Zero dwell and reset: yellow_dwell=0 -> step one cycle after COUNT entry.
REQ-043 Reset mid-COUNT: reset_n pulsed low -> all outputs 0 immediately, IDLE.
